ncl_dual_rail_receiver: RTL and testbench
=========================================

Name: ncl_dual_rail_receiver

Overview:
- Clocked receiver at the far end of a dual-rail NCL datapath, e.g. the 32-bit ripple adder sum bus.
- Samples a WIDTH-bit dual-rail bus and detects DATA and NULL wavefront completeness.
- Drives the NCL acknowledge (ko) back to the async producer.
- Delivers each completed DATA wavefront as a binary word through a 2-entry valid/ready buffer into the clocked domain.

Parameters:
- WIDTH, 32, number of dual-rail bits on the bus.
- SYNC_STAGES, 2, synchronizer flops per rail wire; legal values are 2 or more.

Ports:
- clk  input  1  single clock.
- init  input  1  asynchronous, active-high reset.
- rail0  input  WIDTH  dual-rail 0 wires, asynchronous to clk.
- rail1  input  WIDTH  dual-rail 1 wires, asynchronous to clk.
- ko  output  1  acknowledge to producer: 1 requests DATA, 0 requests NULL.
- out_data  output  WIDTH  binary word; bit i is rail1[i] of the captured wavefront.
- out_valid  output  1  out_data holds a word.
- out_ready  input  1  consumer accepts the word when out_valid && out_ready at a clk edge.
- err  output  1  sticky illegal-code flag (see Optional Feature).

Behaviour:
- Reset: while init=1, all state clears asynchronously.
  - ko=1, out_valid=0, out_data=0, err=0.
  - Buffer count=0, FSM=WAIT_DATA, synchronizer and history registers=0 (NULL).
  - Reset asserted mid-operation discards buffered words and any partial wavefront.
- Sampling:
  - Each rail wire passes through SYNC_STAGES flops; the last stage is S.
  - H is S delayed by one clk.
  - stable = (S == H) across all 2*WIDTH wires.
- Completeness:
  - dcomp: every bit has exactly one of rail0/rail1 high.
  - ncomp: every bit has rail0=rail1=0.
  - Mixed vectors (some bits DATA, some NULL) satisfy neither; the FSM waits.
- space = (count<2) || (out_valid && out_ready).
- FSM has two states:
  - WAIT_DATA (ko=1): if dcomp && stable && space, push S.rail1 into the buffer, set ko<=0, go to WAIT_NULL. If space=0, hold WAIT_DATA with ko=1; the producer is back-pressured by the withheld acknowledge.
  - WAIT_NULL (ko=0): if ncomp && stable, set ko<=1 and go to WAIT_DATA. No other exit.
- ko is registered: it changes on the same edge as the FSM transition.
- Latency, with the DATA wavefront settled before edge E0 and SYNC_STAGES=2:
  - S valid after E1, stable after E2, push at E3.
  - out_valid=1 and ko=0 after E3.
  - General case: SYNC_STAGES+2 edges.
  - NULL → ko=1 has the same latency.
- Buffer: 2-entry FIFO, registered outputs, first-word-fall-through at the head.
  - out_data is stable while out_valid && !out_ready.
  - Simultaneous push and pop when full is legal: count stays 2 and order is preserved.
  - Push into an empty buffer gives out_valid=1 the cycle after the push edge.
  - count is 0..2; it never overflows or underflows.
- A wavefront is consumed exactly once; a DATA wavefront that persists after ko falls is never pushed twice.

Optional Feature:
- Macro: NCL_RX_ILLEGAL_CHECK_EN.
- Defined:
  - Any bit with rail0=rail1=1 in S, in any state, sets err<=1 on that edge.
  - err stays 1 until init.
  - Such a vector never satisfies dcomp or ncomp, so the FSM stalls until the bus becomes legal.
- Undefined:
  - err is tied to 0.
  - A bit with both rails high counts as DATA with value 1, so dcomp tests (rail0|rail1) on every bit.

Test Plan:
- Reset, then DATA 0x00000005 (rail1=0x5, rail0=~0x5), out_ready=1 → out_data=0x00000005, out_valid for 1 cycle, ko falls SYNC_STAGES+2 edges after the rails settle; NULL applied → ko rises after the same latency.
- Back-to-back 4 wavefronts 0xFFFFFFFF, 0x00000000, 0x80000001, 0x12345678, each with NULL between and out_ready=0 → only 2 words buffered, ko stays 1 after the 3rd DATA; then out_ready=1 → all 4 words delivered in order, no duplicates.
- Skewed arrival: bits 0..15 go DATA, then bits 16..31 three cycles later (value 0xABCD1234) → no push until all 32 bits are complete and stable; exactly one word 0xABCD1234 delivered.
- DATA 0x1 held for 20 cycles after ko=0, no NULL → no second push, ko stays 0.
- init pulsed while 2 words are buffered and the FSM is in WAIT_NULL → out_valid=0, ko=1, count=0 immediately; next DATA 0x7 is received normally.
- With NCL_RX_ILLEGAL_CHECK_EN: bit 3 driven rail0=rail1=1 → err=1 within SYNC_STAGES+1 edges, no push; bus then corrected to 0x8 → word 0x8 delivered, err remains 1 until init.

Source files
------------

// File: rtl/ncl_dual_rail_receiver.sv
// ncl_dual_rail_receiver: clocked receiver at the tail of a dual-rail NCL
// datapath. It synchronizes every rail wire, detects DATA and NULL wavefront
// completeness, drives the NCL acknowledge (ko) back to the producer, and
// hands each DATA wavefront to a 2-entry valid/ready buffer.
// Optional build macro: NCL_RX_ILLEGAL_CHECK_EN (sticky err on rail0=rail1=1).

// Per-bit lane: synchronizer chains for both rails, plus one history flop
// per rail so the top level can tell a settled bit from one still moving.
module ncl_rx_lane #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic init,
    input  logic r0,
    input  logic r1,
    output logic s0,
    output logic s1,
    output logic stable
);
    logic [SYNC_STAGES-1:0] sy0, sy1;
    logic                   h0, h1;

    // shift both rails through the synchronizer, remember the last sample
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            sy0 <= '0;
            sy1 <= '0;
            h0  <= 1'b0;
            h1  <= 1'b0;
        end else begin
            sy0 <= {sy0[SYNC_STAGES-2:0], r0};
            sy1 <= {sy1[SYNC_STAGES-2:0], r1};
            h0  <= sy0[SYNC_STAGES-1];
            h1  <= sy1[SYNC_STAGES-1];
        end
    end

    assign s0     = sy0[SYNC_STAGES-1];
    assign s1     = sy1[SYNC_STAGES-1];
    assign stable = (s0 == h0) && (s1 == h1);
endmodule

module ncl_dual_rail_receiver #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             init,
    input  logic [WIDTH-1:0] rail0,
    input  logic [WIDTH-1:0] rail1,
    output logic             ko,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             err
);
    typedef enum logic {WAIT_DATA = 1'b0, WAIT_NULL = 1'b1} state_t;

    logic [WIDTH-1:0] s0, s1, stb;
    logic             stable, dcomp, ncomp, space, push, pop;
    logic [WIDTH-1:0] tail;
    logic [1:0]       count;
    state_t           state;

    for (genvar g = 0; g < WIDTH; g++) begin : g_lane
        ncl_rx_lane #(.SYNC_STAGES(SYNC_STAGES)) u_lane (
            .clk    (clk),
            .init   (init),
            .r0     (rail0[g]),
            .r1     (rail1[g]),
            .s0     (s0[g]),
            .s1     (s1[g]),
            .stable (stb[g])
        );
    end

    assign stable = &stb;
    assign ncomp  = ~|(s0 | s1);
`ifdef NCL_RX_ILLEGAL_CHECK_EN
    // both rails high is illegal: it blocks DATA completeness and flags err
    assign dcomp  = &(s0 ^ s1);
`else
    // both rails high is read as a DATA 1
    assign dcomp  = &(s0 | s1);
`endif

    assign pop   = out_valid && out_ready;
    assign space = (count < 2'd2) || pop;
    // only WAIT_DATA may push, so a lingering DATA wavefront is taken once
    assign push  = (state == WAIT_DATA) && dcomp && stable && space;

    // wavefront FSM; ko is the registered acknowledge
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            state <= WAIT_DATA;
            ko    <= 1'b1;
        end else begin
            case (state)
                WAIT_DATA: if (push) begin
                    state <= WAIT_NULL;
                    ko    <= 1'b0;
                end
                WAIT_NULL: if (ncomp && stable) begin
                    state <= WAIT_DATA;
                    ko    <= 1'b1;
                end
                default: begin
                    state <= WAIT_DATA;
                    ko    <= 1'b1;
                end
            endcase
        end
    end

    // 2-entry FIFO: out_data is the head register, tail holds the second word
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            count     <= 2'd0;
            out_valid <= 1'b0;
            out_data  <= '0;
            tail      <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) out_data <= s1;
                    else               tail     <= s1;
                    count     <= count + 2'd1;
                    out_valid <= 1'b1;
                end
                2'b01: begin
                    out_data  <= tail;
                    count     <= count - 2'd1;
                    out_valid <= (count == 2'd2);
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        out_data <= s1;
                    end else begin
                        out_data <= tail;
                        tail     <= s1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef NCL_RX_ILLEGAL_CHECK_EN
    logic illegal;
    assign illegal = |(s0 & s1);

    // sticky illegal-code flag, cleared only by init
    always_ff @(posedge clk or posedge init) begin
        if (init)         err <= 1'b0;
        else if (illegal) err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_ncl_dual_rail_receiver.sv
// Directed bench for ncl_dual_rail_receiver (WIDTH=32, SYNC_STAGES=2).
module tb_ncl_dual_rail_receiver;
    logic        clk = 1'b0;
    logic        init;
    logic [31:0] rail0, rail1;
    logic        ko;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        err;

    int checks = 0;
    int fails  = 0;
    logic [31:0] q[$];

    ncl_dual_rail_receiver #(.WIDTH(32), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .init      (init),
        .rail0     (rail0),
        .rail1     (rail1),
        .ko        (ko),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err)
    );

    always #5 clk = ~clk;

    // record every word the consumer takes on the following rising edge
    always @(negedge clk)
        if (!init && out_valid === 1'b1 && out_ready === 1'b1) q.push_back(out_data);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_data(input logic [31:0] v);
        rail1 = v;
        rail0 = ~v;
    endtask

    task automatic put_null();
        rail1 = '0;
        rail0 = '0;
    endtask

    task automatic wait_ko(input logic lvl, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (ko === lvl) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        init = 1'b1; out_ready = 1'b0; put_null();
        #2;
        checks++; if (ko !== 1'b1) begin fails++; $display("FAIL reset_ko got=%b want=1", ko); end
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b want=0", out_valid); end
        checks++; if (out_data !== 32'h0) begin fails++; $display("FAIL reset_data got=%h want=0", out_data); end
        checks++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err got=%b want=0", err); end
        tick(); tick();
        init = 1'b0;
        tick();
    endtask

    task automatic test_latency();
        q.delete();
        out_ready = 1'b1;
        put_data(32'h5);
        tick(); tick(); tick();
        checks++; if (ko !== 1'b1) begin fails++; $display("FAIL lat_ko_early got=%b want=1", ko); end
        tick();
        checks++; if (ko !== 1'b0) begin fails++; $display("FAIL lat_ko_fall got=%b want=0", ko); end
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h5) begin fails++;
            $display("FAIL lat_word got=%b/%h want=1/00000005", out_valid, out_data); end
        tick();
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL lat_one_cycle got=%b want=0", out_valid); end
        put_null();
        tick(); tick(); tick();
        checks++; if (ko !== 1'b0) begin fails++; $display("FAIL lat_null_early got=%b want=0", ko); end
        tick();
        checks++; if (ko !== 1'b1) begin fails++; $display("FAIL lat_null_rise got=%b want=1", ko); end
        checks++; if (q.size() != 1 || q[0] !== 32'h5) begin fails++;
            $display("FAIL lat_queue got=%0d words want=1 word 00000005", q.size()); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp [4] = '{32'hFFFFFFFF, 32'h00000000, 32'h80000001, 32'h12345678};
        bit ok;
        int to = 0;
        q.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            put_data(exp[i]); wait_ko(1'b0, ok); if (!ok) to++;
            put_null();       wait_ko(1'b1, ok); if (!ok) to++;
        end
        put_data(exp[2]);
        for (int i = 0; i < 12; i++) tick();
        checks++; if (ko !== 1'b1) begin fails++; $display("FAIL b2b_backpressure_ko got=%b want=1", ko); end
        checks++; if (out_valid !== 1'b1 || out_data !== exp[0]) begin fails++;
            $display("FAIL b2b_head got=%b/%h want=1/%h", out_valid, out_data, exp[0]); end
        out_ready = 1'b1;
        wait_ko(1'b0, ok); if (!ok) to++;
        put_null();       wait_ko(1'b1, ok); if (!ok) to++;
        put_data(exp[3]); wait_ko(1'b0, ok); if (!ok) to++;
        put_null();       wait_ko(1'b1, ok); if (!ok) to++;
        for (int i = 0; i < 6; i++) tick();
        checks++; if (to != 0) begin fails++; $display("FAIL b2b_timeout got=%0d waits expired want=0", to); end
        checks++; if (q.size() != 4) begin fails++; $display("FAIL b2b_count got=%0d want=4", q.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < q.size()) begin
                checks++; if (q[i] !== exp[i]) begin fails++;
                    $display("FAIL b2b_word%0d got=%h want=%h", i, q[i], exp[i]); end
            end
        end
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_drained got=%b want=0", out_valid); end
    endtask

    task automatic test_skew();
        bit ok;
        q.delete();
        out_ready = 1'b1;
        rail1 = 32'h0000_1234;
        rail0 = 32'h0000_EDCB;
        tick(); tick(); tick();
        checks++; if (ko !== 1'b1 || q.size() != 0) begin fails++;
            $display("FAIL skew_partial got ko=%b words=%0d want ko=1 words=0", ko, q.size()); end
        put_data(32'hABCD1234);
        tick(); tick(); tick();
        checks++; if (ko !== 1'b1) begin fails++; $display("FAIL skew_early got=%b want=1", ko); end
        tick();
        checks++; if (ko !== 1'b0) begin fails++; $display("FAIL skew_fall got=%b want=0", ko); end
        put_null(); wait_ko(1'b1, ok);
        tick(); tick();
        checks++; if (!ok) begin fails++; $display("FAIL skew_null_timeout got=ko%b want=ko1", ko); end
        checks++; if (q.size() != 1 || q[0] !== 32'hABCD1234) begin fails++;
            $display("FAIL skew_word got=%0d words want=1 word abcd1234", q.size()); end
    endtask

    task automatic test_hold();
        bit ok;
        int bad = 0;
        q.delete();
        out_ready = 1'b1;
        put_data(32'h1);
        wait_ko(1'b0, ok);
        checks++; if (!ok) begin fails++; $display("FAIL hold_timeout got=ko%b want=ko0", ko); end
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ko !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin fails++; $display("FAIL hold_ko got=%0d cycles with ko!=0 want=0", bad); end
        checks++; if (q.size() != 1 || q[0] !== 32'h1) begin fails++;
            $display("FAIL hold_single got=%0d words want=1", q.size()); end
        put_null(); wait_ko(1'b1, ok);
    endtask

    task automatic test_init_pulse();
        bit ok;
        int to = 0;
        q.delete();
        out_ready = 1'b0;
        put_data(32'hA); wait_ko(1'b0, ok); if (!ok) to++;
        put_null();      wait_ko(1'b1, ok); if (!ok) to++;
        put_data(32'hB); wait_ko(1'b0, ok); if (!ok) to++;
        checks++; if (to != 0 || out_data !== 32'hA) begin fails++;
            $display("FAIL init_setup got timeouts=%0d head=%h want 0/0000000a", to, out_data); end
        init = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || ko !== 1'b1 || out_data !== 32'h0) begin fails++;
            $display("FAIL init_async got valid=%b ko=%b data=%h want 0/1/0", out_valid, ko, out_data); end
        put_null();
        tick(); tick(); tick();
        init = 1'b0;
        q.delete();
        out_ready = 1'b1;
        tick();
        put_data(32'h7); wait_ko(1'b0, ok);
        put_null();      wait_ko(1'b1, ok);
        tick(); tick();
        checks++; if (!ok || q.size() != 1 || q[0] !== 32'h7) begin fails++;
            $display("FAIL init_next got=%0d words ok=%b want=1 word 00000007", q.size(), ok); end
    endtask

    task automatic test_illegal();
        bit ok;
        q.delete();
        out_ready = 1'b1;
        rail1 = 32'h8;
        rail0 = 32'hFFFFFFFF;
`ifdef NCL_RX_ILLEGAL_CHECK_EN
        tick();
        checks++; if (err !== 1'b0) begin fails++; $display("FAIL ill_err_early got=%b want=0", err); end
        tick(); tick();
        checks++; if (err !== 1'b1) begin fails++; $display("FAIL ill_err_set got=%b want=1", err); end
        for (int i = 0; i < 8; i++) tick();
        checks++; if (ko !== 1'b1 || q.size() != 0) begin fails++;
            $display("FAIL ill_no_push got ko=%b words=%0d want 1/0", ko, q.size()); end
        put_data(32'h8);
        wait_ko(1'b0, ok);
        put_null(); wait_ko(1'b1, ok);
        tick(); tick();
        checks++; if (q.size() != 1 || q[0] !== 32'h8) begin fails++;
            $display("FAIL ill_fixed_word got=%0d words want=1 word 00000008", q.size()); end
        checks++; if (err !== 1'b1) begin fails++; $display("FAIL ill_err_sticky got=%b want=1", err); end
        init = 1'b1; #1;
        checks++; if (err !== 1'b0) begin fails++; $display("FAIL ill_err_clear got=%b want=0", err); end
        tick(); init = 1'b0; tick();
`else
        wait_ko(1'b0, ok);
        checks++; if (!ok || err !== 1'b0) begin fails++;
            $display("FAIL both_high_data got ok=%b err=%b want 1/0", ok, err); end
        put_null(); wait_ko(1'b1, ok);
        tick(); tick();
        checks++; if (q.size() != 1 || q[0] !== 32'h8) begin fails++;
            $display("FAIL both_high_word got=%0d words want=1 word 00000008", q.size()); end
`endif
    endtask

    initial begin
        test_reset();
        test_latency();
        test_back_to_back();
        test_skew();
        test_hold();
        test_init_pulse();
        test_illegal();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end
endmodule
